// File: rtl/sc_regbank_pkg.sv
// -----------------------------------------------------------------------------
// sc_regbank_pkg
// Shared datapath constants and the FSM state encoding for the sc_regbank
// register bank. No ports; imported by the bank, its register cell and its
// bus interface.
// -----------------------------------------------------------------------------
package sc_regbank_pkg;

  localparam int DATAWIDTH_BUS               = 32;
  localparam int DATAWIDTH_DECODER_SELECTION = 6;
  localparam int REG_COUNT                   = 38;
  // Highest valid register index; also the terminal value of the clear sweep.
  localparam int LAST_IDX                    = 37;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

endpackage

// File: rtl/sc_regbank_if.sv
// -----------------------------------------------------------------------------
// sc_regbank_if
// Write/clear bus bundle for sc_regbank.
//   wreq  : write request (valid), held by the master until ack or err
//   addr  : target register index
//   data  : write data
//   clear : single-cycle soft-clear request
//   ack   : one-cycle pulse, write accepted (acts as ready for wreq)
//   err   : one-cycle pulse, write rejected (bad address)
//   busy  : high while the clear sweep runs
// Handshake: a write completes on the cycle ack or err is seen high; the
// master must keep wreq/addr/data stable until then and may drop wreq or
// present the next request on the following cycle.
// Modports: master (drives requests), slave (answers them).
// -----------------------------------------------------------------------------
interface sc_regbank_if #(
  parameter int DW = sc_regbank_pkg::DATAWIDTH_BUS,
  parameter int AW = sc_regbank_pkg::DATAWIDTH_DECODER_SELECTION
);
  logic          wreq;
  logic [AW-1:0] addr;
  logic [DW-1:0] data;
  logic          clear;
  logic          ack;
  logic          err;
  logic          busy;

  modport master (output wreq, addr, data, clear, input ack, err, busy);
  modport slave  (input wreq, addr, data, clear, output ack, err, busy);
endinterface

// File: rtl/sc_regbank_reggeneral.sv
// -----------------------------------------------------------------------------
// sc_reggeneral
// One register of the bank: DATAWIDTH_BUS bits with load, synchronous clear
// and asynchronous active-low reset. Clear wins over load.
//   i_clk   : clock, rising edge
//   i_rst_n : asynchronous active-low reset
//   i_load  : load i_data on the next edge
//   i_clear : zero the register on the next edge
//   i_data  : load data
//   o_data  : register contents
// -----------------------------------------------------------------------------
module sc_reggeneral #(
  parameter int DATAWIDTH_BUS = sc_regbank_pkg::DATAWIDTH_BUS
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_load,
  input  logic                     i_clear,
  input  logic [DATAWIDTH_BUS-1:0] i_data,
  output logic [DATAWIDTH_BUS-1:0] o_data
);

  logic [DATAWIDTH_BUS-1:0] r_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)     r_q <= '0;
    else if (i_clear) r_q <= '0;
    else if (i_load)  r_q <= i_data;
  end

  assign o_data = r_q;

endmodule

// File: rtl/sc_regbank.sv
// -----------------------------------------------------------------------------
// sc_regbank
// 38-entry register bank. Register 0 is hard-wired to zero, registers 1..37
// are written through a request/ack bus. A clear pulse starts a sweep that
// zeroes registers 1..37, one per cycle, while Busy_Out is high.
//   SC_REGBANK_CLOCK_50        : clock, rising edge
//   SC_REGBANK_RESET_InLow     : asynchronous active-low reset
//   SC_REGBANK_WriteReq_In     : write request, held until Ack or Err
//   SC_REGBANK_Address_In      : target register index
//   SC_REGBANK_DataBUS_In      : write data
//   SC_REGBANK_Clear_In        : soft-clear pulse
//   SC_REGBANK_DataBUS_Out_0..37 : register contents (registered)
//   SC_REGBANK_Ack_Out / Err_Out : one-cycle write accept / reject pulses
//   SC_REGBANK_Busy_Out        : clear sweep in progress
// -----------------------------------------------------------------------------
module sc_regbank #(
  parameter int DATAWIDTH_BUS               = sc_regbank_pkg::DATAWIDTH_BUS,
  parameter int DATAWIDTH_DECODER_SELECTION = sc_regbank_pkg::DATAWIDTH_DECODER_SELECTION,
  parameter int REG_COUNT                   = sc_regbank_pkg::REG_COUNT
) (
  input  logic                                   SC_REGBANK_CLOCK_50,
  input  logic                                   SC_REGBANK_RESET_InLow,
  input  logic                                   SC_REGBANK_WriteReq_In,
  input  logic [DATAWIDTH_DECODER_SELECTION-1:0] SC_REGBANK_Address_In,
  input  logic [DATAWIDTH_BUS-1:0]               SC_REGBANK_DataBUS_In,
  input  logic                                   SC_REGBANK_Clear_In,
  output logic [DATAWIDTH_BUS-1:0] SC_REGBANK_DataBUS_Out_0,  SC_REGBANK_DataBUS_Out_1,
  output logic [DATAWIDTH_BUS-1:0] SC_REGBANK_DataBUS_Out_2,  SC_REGBANK_DataBUS_Out_3,
  output logic [DATAWIDTH_BUS-1:0] SC_REGBANK_DataBUS_Out_4,  SC_REGBANK_DataBUS_Out_5,
  output logic [DATAWIDTH_BUS-1:0] SC_REGBANK_DataBUS_Out_6,  SC_REGBANK_DataBUS_Out_7,
  output logic [DATAWIDTH_BUS-1:0] SC_REGBANK_DataBUS_Out_8,  SC_REGBANK_DataBUS_Out_9,
  output logic [DATAWIDTH_BUS-1:0] SC_REGBANK_DataBUS_Out_10, SC_REGBANK_DataBUS_Out_11,
  output logic [DATAWIDTH_BUS-1:0] SC_REGBANK_DataBUS_Out_12, SC_REGBANK_DataBUS_Out_13,
  output logic [DATAWIDTH_BUS-1:0] SC_REGBANK_DataBUS_Out_14, SC_REGBANK_DataBUS_Out_15,
  output logic [DATAWIDTH_BUS-1:0] SC_REGBANK_DataBUS_Out_16, SC_REGBANK_DataBUS_Out_17,
  output logic [DATAWIDTH_BUS-1:0] SC_REGBANK_DataBUS_Out_18, SC_REGBANK_DataBUS_Out_19,
  output logic [DATAWIDTH_BUS-1:0] SC_REGBANK_DataBUS_Out_20, SC_REGBANK_DataBUS_Out_21,
  output logic [DATAWIDTH_BUS-1:0] SC_REGBANK_DataBUS_Out_22, SC_REGBANK_DataBUS_Out_23,
  output logic [DATAWIDTH_BUS-1:0] SC_REGBANK_DataBUS_Out_24, SC_REGBANK_DataBUS_Out_25,
  output logic [DATAWIDTH_BUS-1:0] SC_REGBANK_DataBUS_Out_26, SC_REGBANK_DataBUS_Out_27,
  output logic [DATAWIDTH_BUS-1:0] SC_REGBANK_DataBUS_Out_28, SC_REGBANK_DataBUS_Out_29,
  output logic [DATAWIDTH_BUS-1:0] SC_REGBANK_DataBUS_Out_30, SC_REGBANK_DataBUS_Out_31,
  output logic [DATAWIDTH_BUS-1:0] SC_REGBANK_DataBUS_Out_32, SC_REGBANK_DataBUS_Out_33,
  output logic [DATAWIDTH_BUS-1:0] SC_REGBANK_DataBUS_Out_34, SC_REGBANK_DataBUS_Out_35,
  output logic [DATAWIDTH_BUS-1:0] SC_REGBANK_DataBUS_Out_36, SC_REGBANK_DataBUS_Out_37,
  output logic                     SC_REGBANK_Ack_Out,
  output logic                     SC_REGBANK_Err_Out,
  output logic                     SC_REGBANK_Busy_Out
);

  import sc_regbank_pkg::*;

  localparam int AW = DATAWIDTH_DECODER_SELECTION;
  localparam logic [AW-1:0] LAST_IDX_W = AW'(LAST_IDX);

  state_t        r_state, w_state_nxt;
  logic [AW-1:0] r_cnt, w_cnt_nxt;
  logic          r_ack, r_err;
  logic          w_ack_nxt, w_err_nxt;
  logic          w_wr_en, w_clr_en, w_addr_ok;

  logic [DATAWIDTH_BUS-1:0] w_regs [REG_COUNT];

  assign w_addr_ok = (SC_REGBANK_Address_In != '0) && (SC_REGBANK_Address_In <= LAST_IDX_W);

  always_ff @(posedge SC_REGBANK_CLOCK_50 or negedge SC_REGBANK_RESET_InLow) begin
    if (!SC_REGBANK_RESET_InLow) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_ack   <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_ack   <= w_ack_nxt;
      r_err   <= w_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_wr_en     = 1'b0;
    w_clr_en    = 1'b0;
    w_ack_nxt   = 1'b0;
    w_err_nxt   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (SC_REGBANK_Clear_In) begin
          w_state_nxt = ST_CLEAR;
          w_cnt_nxt   = AW'(1);
        end else if (SC_REGBANK_WriteReq_In && !r_ack && !r_err) begin
          // A pulse in flight means the master has not yet seen the answer to
          // the current request, so the still-held request is not re-serviced.
          if (w_addr_ok) begin
            w_wr_en   = 1'b1;
            w_ack_nxt = 1'b1;
          end else begin
            w_err_nxt = 1'b1;
          end
        end
      end
      ST_CLEAR: begin
        w_clr_en = 1'b1;
        if (r_cnt == LAST_IDX_W) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + AW'(1);
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_regs[0] = '0;

  for (genvar gi = 1; gi < REG_COUNT; gi++) begin : g_reg
    sc_reggeneral #(.DATAWIDTH_BUS(DATAWIDTH_BUS)) u_reg (
      .i_clk   (SC_REGBANK_CLOCK_50),
      .i_rst_n (SC_REGBANK_RESET_InLow),
      .i_load  (w_wr_en && (SC_REGBANK_Address_In == AW'(gi))),
      .i_clear (w_clr_en && (r_cnt == AW'(gi))),
      .i_data  (SC_REGBANK_DataBUS_In),
      .o_data  (w_regs[gi])
    );
  end

  assign SC_REGBANK_Ack_Out  = r_ack;
  assign SC_REGBANK_Err_Out  = r_err;
  assign SC_REGBANK_Busy_Out = (r_state == ST_CLEAR);

  assign SC_REGBANK_DataBUS_Out_0  = w_regs[0];
  assign SC_REGBANK_DataBUS_Out_1  = w_regs[1];
  assign SC_REGBANK_DataBUS_Out_2  = w_regs[2];
  assign SC_REGBANK_DataBUS_Out_3  = w_regs[3];
  assign SC_REGBANK_DataBUS_Out_4  = w_regs[4];
  assign SC_REGBANK_DataBUS_Out_5  = w_regs[5];
  assign SC_REGBANK_DataBUS_Out_6  = w_regs[6];
  assign SC_REGBANK_DataBUS_Out_7  = w_regs[7];
  assign SC_REGBANK_DataBUS_Out_8  = w_regs[8];
  assign SC_REGBANK_DataBUS_Out_9  = w_regs[9];
  assign SC_REGBANK_DataBUS_Out_10 = w_regs[10];
  assign SC_REGBANK_DataBUS_Out_11 = w_regs[11];
  assign SC_REGBANK_DataBUS_Out_12 = w_regs[12];
  assign SC_REGBANK_DataBUS_Out_13 = w_regs[13];
  assign SC_REGBANK_DataBUS_Out_14 = w_regs[14];
  assign SC_REGBANK_DataBUS_Out_15 = w_regs[15];
  assign SC_REGBANK_DataBUS_Out_16 = w_regs[16];
  assign SC_REGBANK_DataBUS_Out_17 = w_regs[17];
  assign SC_REGBANK_DataBUS_Out_18 = w_regs[18];
  assign SC_REGBANK_DataBUS_Out_19 = w_regs[19];
  assign SC_REGBANK_DataBUS_Out_20 = w_regs[20];
  assign SC_REGBANK_DataBUS_Out_21 = w_regs[21];
  assign SC_REGBANK_DataBUS_Out_22 = w_regs[22];
  assign SC_REGBANK_DataBUS_Out_23 = w_regs[23];
  assign SC_REGBANK_DataBUS_Out_24 = w_regs[24];
  assign SC_REGBANK_DataBUS_Out_25 = w_regs[25];
  assign SC_REGBANK_DataBUS_Out_26 = w_regs[26];
  assign SC_REGBANK_DataBUS_Out_27 = w_regs[27];
  assign SC_REGBANK_DataBUS_Out_28 = w_regs[28];
  assign SC_REGBANK_DataBUS_Out_29 = w_regs[29];
  assign SC_REGBANK_DataBUS_Out_30 = w_regs[30];
  assign SC_REGBANK_DataBUS_Out_31 = w_regs[31];
  assign SC_REGBANK_DataBUS_Out_32 = w_regs[32];
  assign SC_REGBANK_DataBUS_Out_33 = w_regs[33];
  assign SC_REGBANK_DataBUS_Out_34 = w_regs[34];
  assign SC_REGBANK_DataBUS_Out_35 = w_regs[35];
  assign SC_REGBANK_DataBUS_Out_36 = w_regs[36];
  assign SC_REGBANK_DataBUS_Out_37 = w_regs[37];

endmodule

// File: tb/tb_sc_regbank.sv
module tb_sc_regbank;

  localparam int DW = 32;
  localparam int AW = 6;
  localparam int NR = 38;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  sc_regbank_if #(.DW(DW), .AW(AW)) bus ();

  logic [DW-1:0] dout [NR];

  sc_regbank dut (
    .SC_REGBANK_CLOCK_50     (clk),
    .SC_REGBANK_RESET_InLow  (rst_n),
    .SC_REGBANK_WriteReq_In  (bus.wreq),
    .SC_REGBANK_Address_In   (bus.addr),
    .SC_REGBANK_DataBUS_In   (bus.data),
    .SC_REGBANK_Clear_In     (bus.clear),
    .SC_REGBANK_DataBUS_Out_0  (dout[0]),  .SC_REGBANK_DataBUS_Out_1  (dout[1]),
    .SC_REGBANK_DataBUS_Out_2  (dout[2]),  .SC_REGBANK_DataBUS_Out_3  (dout[3]),
    .SC_REGBANK_DataBUS_Out_4  (dout[4]),  .SC_REGBANK_DataBUS_Out_5  (dout[5]),
    .SC_REGBANK_DataBUS_Out_6  (dout[6]),  .SC_REGBANK_DataBUS_Out_7  (dout[7]),
    .SC_REGBANK_DataBUS_Out_8  (dout[8]),  .SC_REGBANK_DataBUS_Out_9  (dout[9]),
    .SC_REGBANK_DataBUS_Out_10 (dout[10]), .SC_REGBANK_DataBUS_Out_11 (dout[11]),
    .SC_REGBANK_DataBUS_Out_12 (dout[12]), .SC_REGBANK_DataBUS_Out_13 (dout[13]),
    .SC_REGBANK_DataBUS_Out_14 (dout[14]), .SC_REGBANK_DataBUS_Out_15 (dout[15]),
    .SC_REGBANK_DataBUS_Out_16 (dout[16]), .SC_REGBANK_DataBUS_Out_17 (dout[17]),
    .SC_REGBANK_DataBUS_Out_18 (dout[18]), .SC_REGBANK_DataBUS_Out_19 (dout[19]),
    .SC_REGBANK_DataBUS_Out_20 (dout[20]), .SC_REGBANK_DataBUS_Out_21 (dout[21]),
    .SC_REGBANK_DataBUS_Out_22 (dout[22]), .SC_REGBANK_DataBUS_Out_23 (dout[23]),
    .SC_REGBANK_DataBUS_Out_24 (dout[24]), .SC_REGBANK_DataBUS_Out_25 (dout[25]),
    .SC_REGBANK_DataBUS_Out_26 (dout[26]), .SC_REGBANK_DataBUS_Out_27 (dout[27]),
    .SC_REGBANK_DataBUS_Out_28 (dout[28]), .SC_REGBANK_DataBUS_Out_29 (dout[29]),
    .SC_REGBANK_DataBUS_Out_30 (dout[30]), .SC_REGBANK_DataBUS_Out_31 (dout[31]),
    .SC_REGBANK_DataBUS_Out_32 (dout[32]), .SC_REGBANK_DataBUS_Out_33 (dout[33]),
    .SC_REGBANK_DataBUS_Out_34 (dout[34]), .SC_REGBANK_DataBUS_Out_35 (dout[35]),
    .SC_REGBANK_DataBUS_Out_36 (dout[36]), .SC_REGBANK_DataBUS_Out_37 (dout[37]),
    .SC_REGBANK_Ack_Out      (bus.ack),
    .SC_REGBANK_Err_Out      (bus.err),
    .SC_REGBANK_Busy_Out     (bus.busy)
  );

  // ---------------- scoreboard ----------------
  logic [DW-1:0] exp_regs [NR];
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic check_all(input string tag);
    for (int i = 0; i < NR; i++)
      check($sformatf("%s reg%0d", tag, i), dout[i], exp_regs[i]);
  endtask

  task automatic check_flags(input string tag, input logic ack, input logic err, input logic busy);
    check({tag, " ack"},  {31'b0, bus.ack},  {31'b0, ack});
    check({tag, " err"},  {31'b0, bus.err},  {31'b0, err});
    check({tag, " busy"}, {31'b0, bus.busy}, {31'b0, busy});
  endtask

  task automatic model_reset();
    for (int i = 0; i < NR; i++) exp_regs[i] = '0;
  endtask

  // ---------------- drivers ----------------
  // All drivers start and end just after a falling edge.
  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input bit ok);
    bus.wreq = 1'b1;
    bus.addr = a;
    bus.data = d;
    @(posedge clk);
    @(negedge clk);
    check_flags($sformatf("wr a%0d", a), ok, !ok, 1'b0);
    if (ok) exp_regs[a] = d;
    bus.wreq = 1'b0;
    @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  int busy_cnt;
  int ack_cnt;
  int bad_pulse;

  initial begin
    rst_n     = 1'b0;
    bus.wreq  = 1'b0;
    bus.addr  = '0;
    bus.data  = '0;
    bus.clear = 1'b0;
    model_reset();
    #1;
    check_all("reset");
    check_flags("reset", 1'b0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic write
    do_write(6'd5, 32'hDEADBEEF, 1'b1);
    check_all("wr5");

    // Rejected addresses
    do_write(6'd0, 32'h12345678, 1'b0);
    do_write(6'd40, 32'h12345678, 1'b0);
    do_write(6'd38, 32'h12345678, 1'b0);
    check_all("err");

    // Held request: serviced on alternate edges only
    bus.wreq = 1'b1;
    bus.addr = 6'd7;
    bus.data = 32'h00000077;
    ack_cnt = 0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.ack) ack_cnt++;
      check($sformatf("hold ack c%0d", k), {31'b0, bus.ack}, {31'b0, (k % 2 == 0)});
    end
    bus.wreq = 1'b0;
    exp_regs[7] = 32'h00000077;
    check("hold ack count", ack_cnt, 2);
    @(negedge clk);
    check_all("hold");

    // Fill 1..37 with their index, then sweep
    for (int i = 1; i < NR; i++) do_write(AW'(i), DW'(i), 1'b1);
    check_all("fill");
    bus.clear = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.clear = 1'b0;
    busy_cnt  = bus.busy ? 1 : 0;
    bad_pulse = 0;
    check("sweep enter busy", {31'b0, bus.busy}, 32'd1);
    for (int k = 1; k < NR; k++) begin
      @(posedge clk);
      @(negedge clk);
      exp_regs[k] = '0;
      if (bus.busy) busy_cnt++;
      if (bus.ack || bus.err) bad_pulse++;
      check($sformatf("sweep reg%0d", k), dout[k], '0);
      if (k < NR - 1)
        check($sformatf("sweep keep reg%0d", k + 1), dout[k + 1], exp_regs[k + 1]);
    end
    check("sweep busy cycles", busy_cnt, 37);
    check("sweep pulses", bad_pulse, 0);
    check_flags("sweep end", 1'b0, 1'b0, 1'b0);
    check_all("sweep end");

    // Clear beats a simultaneous write; the write is ignored during the
    // sweep, a second clear is ignored, and the held write lands afterwards.
    bus.clear = 1'b1;
    bus.wreq  = 1'b1;
    bus.addr  = 6'd3;
    bus.data  = 32'hA5A5A5A5;
    @(posedge clk);
    @(negedge clk);
    bus.clear = 1'b0;
    check_flags("prio enter", 1'b0, 1'b0, 1'b1);
    busy_cnt  = 1;
    bad_pulse = 0;
    for (int k = 1; k < NR; k++) begin
      bus.clear = (k == 10);
      @(posedge clk);
      @(negedge clk);
      if (bus.busy) busy_cnt++;
      if (bus.ack || bus.err) bad_pulse++;
    end
    bus.clear = 1'b0;
    check("prio busy cycles", busy_cnt, 37);
    check("prio pulses", bad_pulse, 0);
    check("prio reg3 before", dout[3], '0);
    @(posedge clk);
    @(negedge clk);
    check_flags("prio ack", 1'b1, 1'b0, 1'b0);
    exp_regs[3] = 32'hA5A5A5A5;
    bus.wreq = 1'b0;
    @(negedge clk);
    check_all("prio");

    // Reset mid-sweep
    do_write(6'd2, 32'h22222222, 1'b1);
    do_write(6'd37, 32'h37373737, 1'b1);
    bus.clear = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.clear = 1'b0;
    repeat (10) begin
      @(posedge clk);
      @(negedge clk);
    end
    check("midsweep busy", {31'b0, bus.busy}, 32'd1);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all("rst sweep");
    check_flags("rst sweep", 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_flags("rst sweep release", 1'b0, 1'b0, 1'b0);

    // Reset mid-write, with the ack pulse and new data in flight
    do_write(6'd9, 32'h99999999, 1'b1);
    bus.wreq = 1'b1;
    bus.addr = 6'd4;
    bus.data = 32'h44444444;
    @(posedge clk);
    #2;
    check("midwrite ack", {31'b0, bus.ack}, 32'd1);
    check("midwrite reg4", dout[4], 32'h44444444);
    rst_n    = 1'b0;
    bus.wreq = 1'b0;
    model_reset();
    #1;
    check_all("rst write");
    check_flags("rst write", 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_write(6'd37, 32'hFFFFFFFF, 1'b1);
    check_all("post reset");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

endmodule
